// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: result classes,
// forward select codes, the E/M tracking record and tnew helpers.
package hazard_ctrl_pkg;

   localparam int unsigned AW   = 5;
   localparam int unsigned RESW = 2;
   localparam int unsigned FSW  = 2;
   localparam int unsigned TUW  = 2;

   typedef enum logic [RESW-1:0] {
      RES_NW  = 2'd0,
      RES_ALU = 2'd1,
      RES_DM  = 2'd2,
      RES_PC  = 2'd3
   } res_t;

   typedef enum logic [FSW-1:0] {
      FWD_NONE = 2'd0,
      FWD_EPC8 = 2'd1,
      FWD_M    = 2'd2,
      FWD_W    = 2'd3
   } fwd_t;

   // tuse value meaning "operand not read"; larger than any tnew so it never stalls
   localparam logic [TUW-1:0] TUSE_NONE = 2'd3;

   typedef struct packed {
      logic [AW-1:0] ra1;
      logic [AW-1:0] ra2;
      logic [AW-1:0] wa;
      res_t          res;
      logic          md_start;
   } trk_t;

   function automatic logic [TUW-1:0] tnew_e(input res_t r);
      logic [TUW-1:0] t;
      case (r)
         RES_ALU: t = 2'd1;
         RES_DM:  t = 2'd2;
         default: t = 2'd0;
      endcase
      return t;
   endfunction

   function automatic logic [TUW-1:0] tnew_m(input res_t r);
      return (r == RES_DM) ? 2'd1 : 2'd0;
   endfunction

   // A stage produces register a only for a real, nonzero write to a
   function automatic logic is_producer(input logic [AW-1:0] wa,
                                        input res_t          r,
                                        input logic [AW-1:0] a);
      return (wa == a) && (a != '0) && (r != RES_NW);
   endfunction

endpackage

// File: rtl/atc_stage.sv
// One pipeline tracking register {ra1, ra2, wa, res, md_start}; flush loads a bubble.
module atc_stage
   import hazard_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  trk_t d,
   output trk_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tuse/tnew stall detection, operand forward
// selects for D/E/M, and the mult/div busy counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [AW-1:0]  ra1D,
   input  logic [AW-1:0]  ra2D,
   input  logic [AW-1:0]  waD,
   input  logic [RESW-1:0] resD,
   input  logic [TUW-1:0] tuse1D,
   input  logic [TUW-1:0] tuse2D,
   input  logic           mdD,
   input  logic           mdStartD,
   input  logic           mdDivD,
   input  logic [AW-1:0]  waW,
   input  logic [RESW-1:0] resW,
   output logic           stall,
   output logic [FSW-1:0] fwdRsD,
   output logic [FSW-1:0] fwdRtD,
   output logic [FSW-1:0] fwdRsE,
   output logic [FSW-1:0] fwdRtE,
   output logic [FSW-1:0] fwdRtM,
   output logic           busy
);

   localparam int unsigned CMAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   trk_t          d_trk;
   trk_t          e_trk;
   trk_t          m_trk;
   res_t          w_res;
   logic          div_e;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          unused_m;

   assign d_trk = '{ra1: ra1D, ra2: ra2D, wa: waD, res: res_t'(resD), md_start: mdStartD};
   assign w_res = res_t'(resW);

   // M only feeds store-data forwarding, so its ra1 and start flag are dead
   assign unused_m = ^{m_trk.ra1, m_trk.md_start};

   atc_stage u_e (
      .clk   (clk),
      .rst   (rst),
      .flush (stall),
      .d     (d_trk),
      .q     (e_trk)
   );

   atc_stage u_m (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .d     (e_trk),
      .q     (m_trk)
   );

   // Only the nearest producer decides; a nearer stage shadows older ones
   function automatic logic op_stall(input logic [AW-1:0]  a,
                                     input logic [TUW-1:0] tuse,
                                     input logic [AW-1:0]  e_wa,
                                     input res_t           e_res,
                                     input logic [AW-1:0]  m_wa,
                                     input res_t           m_res);
      logic s;
      s = 1'b0;
      if (is_producer(e_wa, e_res, a)) begin
         s = (tuse < tnew_e(e_res));
      end else if (is_producer(m_wa, m_res, a)) begin
         s = (tuse < tnew_m(m_res));
      end
      return s;
   endfunction

   function automatic fwd_t fwd_to_d(input logic [AW-1:0] a,
                                     input logic [AW-1:0] e_wa,
                                     input res_t          e_res,
                                     input logic [AW-1:0] m_wa,
                                     input res_t          m_res,
                                     input logic [AW-1:0] w_wa,
                                     input res_t          w_r);
      fwd_t f;
      f = FWD_NONE;
      if (is_producer(e_wa, e_res, a)) begin
         f = (e_res == RES_PC) ? FWD_EPC8 : FWD_NONE;
      end else if (is_producer(m_wa, m_res, a)) begin
         f = (tnew_m(m_res) == '0) ? FWD_M : FWD_NONE;
      end else if (is_producer(w_wa, w_r, a)) begin
         f = FWD_W;
      end
      return f;
   endfunction

   function automatic fwd_t fwd_to_e(input logic [AW-1:0] a,
                                     input logic [AW-1:0] m_wa,
                                     input res_t          m_res,
                                     input logic [AW-1:0] w_wa,
                                     input res_t          w_r);
      fwd_t f;
      f = FWD_NONE;
      if (is_producer(m_wa, m_res, a)) begin
         f = (tnew_m(m_res) == '0) ? FWD_M : FWD_NONE;
      end else if (is_producer(w_wa, w_r, a)) begin
         f = FWD_W;
      end
      return f;
   endfunction

   function automatic fwd_t fwd_to_m(input logic [AW-1:0] a,
                                     input logic [AW-1:0] w_wa,
                                     input res_t          w_r);
      return is_producer(w_wa, w_r, a) ? FWD_W : FWD_NONE;
   endfunction

   // Stall and forward selects; all held at zero during reset
   always_comb begin
      stall  = 1'b0;
      fwdRsD = FSW'(FWD_NONE);
      fwdRtD = FSW'(FWD_NONE);
      fwdRsE = FSW'(FWD_NONE);
      fwdRtE = FSW'(FWD_NONE);
      fwdRtM = FSW'(FWD_NONE);
      if (!rst) begin
         stall  = op_stall(ra1D, tuse1D, e_trk.wa, e_trk.res, m_trk.wa, m_trk.res)
                | op_stall(ra2D, tuse2D, e_trk.wa, e_trk.res, m_trk.wa, m_trk.res)
                | (mdD & (busy | e_trk.md_start));
         fwdRsD = FSW'(fwd_to_d(ra1D, e_trk.wa, e_trk.res, m_trk.wa, m_trk.res, waW, w_res));
         fwdRtD = FSW'(fwd_to_d(ra2D, e_trk.wa, e_trk.res, m_trk.wa, m_trk.res, waW, w_res));
         fwdRsE = FSW'(fwd_to_e(e_trk.ra1, m_trk.wa, m_trk.res, waW, w_res));
         fwdRtE = FSW'(fwd_to_e(e_trk.ra2, m_trk.wa, m_trk.res, waW, w_res));
         fwdRtM = FSW'(fwd_to_m(m_trk.ra2, waW, w_res));
      end
   end

   // Start in E loads the counter at the end of its E cycle; a start while busy is dropped
   always_comb begin
      cnt_nxt = cnt;
      if (e_trk.md_start && !busy) begin
         cnt_nxt = div_e ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (cnt != '0) begin
         cnt_nxt = cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         busy  <= 1'b0;
         div_e <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         busy  <= (cnt_nxt != '0);
         div_e <= mdDivD & ~stall;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, forward selects, mult/div busy and reset.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ra1D, ra2D, waD, waW;
   logic [1:0] resD, tuse1D, tuse2D, resW;
   logic       mdD, mdStartD, mdDivD;
   logic       stall, busy;
   logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] TN = 2'd3;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .ra1D     (ra1D),
      .ra2D     (ra2D),
      .waD      (waD),
      .resD     (resD),
      .tuse1D   (tuse1D),
      .tuse2D   (tuse2D),
      .mdD      (mdD),
      .mdStartD (mdStartD),
      .mdDivD   (mdDivD),
      .waW      (waW),
      .resW     (resW),
      .stall    (stall),
      .fwdRsD   (fwdRsD),
      .fwdRtD   (fwdRtD),
      .fwdRsE   (fwdRsE),
      .fwdRtE   (fwdRtE),
      .fwdRtM   (fwdRtM),
      .busy     (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] w,
                        input logic [1:0] r, input logic [1:0] t1, input logic [1:0] t2,
                        input logic md, input logic ms, input logic mv);
      ra1D = a1; ra2D = a2; waD = w; resD = r; tuse1D = t1; tuse2D = t2;
      mdD = md; mdStartD = ms; mdDivD = mv;
      #1;
   endtask

   task automatic set_w(input logic [4:0] w, input logic [1:0] r);
      waW = w; resW = r;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_w(5'd4, RES_ALU);
      set_d(5'd4, 5'd4, 5'd0, RES_NW, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b exp 0", stall); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b exp 0", busy); end
      total++; if (fwdRsD !== 2'd0) begin bad++; $display("FAIL rst_fwdRsD: got %0d exp 0", fwdRsD); end
      total++; if (fwdRtD !== 2'd0) begin bad++; $display("FAIL rst_fwdRtD: got %0d exp 0", fwdRtD); end
      total++; if ({fwdRsE, fwdRtE, fwdRtM} !== 6'd0) begin bad++; $display("FAIL rst_fwdEM: got %b exp 000000", {fwdRsE, fwdRtE, fwdRtM}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (fwdRsD !== 2'd3) begin bad++; $display("FAIL post_rst_w_fwd: got %0d exp 3", fwdRsD); end
      set_w(5'd0, RES_NW);
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_load_use();
      set_w(5'd0, RES_NW);
      set_d(5'd0, 5'd0, 5'd8, RES_DM, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_d(5'd8, 5'd0, 5'd0, RES_NW, 2'd1, TN, 1'b0, 1'b0, 1'b0);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %0b exp 1", stall); end
      total++; if (fwdRsD !== 2'd0) begin bad++; $display("FAIL lu_fwdRsD_e: got %0d exp 0", fwdRsD); end
      step();
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %0b exp 0", stall); end
      tuse1D = 2'd0; #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_m_tuse0: got %0b exp 1", stall); end
      tuse1D = 2'd1; #1;
      step();
      set_w(5'd8, RES_DM); #1;
      total++; if (fwdRsE !== 2'd3) begin bad++; $display("FAIL lu_fwdRsE: got %0d exp 3", fwdRsE); end
      total++; if (fwdRsD !== 2'd3) begin bad++; $display("FAIL lu_fwdRsD_w: got %0d exp 3", fwdRsD); end
      set_w(5'd0, RES_NW);
   endtask

   task automatic test_alu_b2b();
      set_d(5'd0, 5'd0, 5'd5, RES_ALU, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_d(5'd0, 5'd5, 5'd0, RES_NW, TN, 2'd1, 1'b0, 1'b0, 1'b0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %0b exp 0", stall); end
      total++; if (fwdRtD !== 2'd0) begin bad++; $display("FAIL alu_fwdRtD: got %0d exp 0", fwdRtD); end
      step();
      total++; if (fwdRtE !== 2'd2) begin bad++; $display("FAIL alu_fwdRtE: got %0d exp 2", fwdRtE); end
      total++; if (fwdRsE !== 2'd0) begin bad++; $display("FAIL alu_fwdRsE: got %0d exp 0", fwdRsE); end
   endtask

   task automatic test_link();
      set_d(5'd0, 5'd0, 5'd31, RES_PC, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_d(5'd31, 5'd0, 5'd0, RES_NW, 2'd0, TN, 1'b0, 1'b0, 1'b0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL link_stall: got %0b exp 0", stall); end
      total++; if (fwdRsD !== 2'd1) begin bad++; $display("FAIL link_fwdRsD: got %0d exp 1", fwdRsD); end
   endtask

   task automatic test_zero_nw();
      set_w(5'd0, RES_NW);
      set_d(5'd0, 5'd0, 5'd3, RES_NW, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_d(5'd0, 5'd0, 5'd0, RES_ALU, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_d(5'd0, 5'd3, 5'd0, RES_NW, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall: got %0b exp 0", stall); end
      total++; if ({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM} !== 10'd0) begin
         bad++; $display("FAIL zero_fwd: got %b exp 0000000000", {fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM});
      end
   endtask

   task automatic test_m_w_priority();
      set_d(5'd0, 5'd6, 5'd9, RES_ALU, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b0, 1'b0);
      step();
      set_w(5'd6, RES_ALU);
      set_d(5'd9, 5'd6, 5'd0, RES_NW, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL pri_stall: got %0b exp 0", stall); end
      total++; if (fwdRsD !== 2'd2) begin bad++; $display("FAIL pri_fwdRsD_m: got %0d exp 2", fwdRsD); end
      total++; if (fwdRtD !== 2'd3) begin bad++; $display("FAIL pri_fwdRtD_w: got %0d exp 3", fwdRtD); end
      total++; if (fwdRtM !== 2'd3) begin bad++; $display("FAIL pri_fwdRtM_w: got %0d exp 3", fwdRtM); end
      set_w(5'd9, RES_ALU); #1;
      total++; if (fwdRsD !== 2'd2) begin bad++; $display("FAIL pri_m_over_w: got %0d exp 2", fwdRsD); end
      total++; if (fwdRtM !== 2'd0) begin bad++; $display("FAIL pri_fwdRtM_none: got %0d exp 0", fwdRtM); end
      set_w(5'd6, RES_NW); #1;
      total++; if (fwdRtD !== 2'd0) begin bad++; $display("FAIL pri_w_nw: got %0d exp 0", fwdRtD); end
      set_w(5'd0, RES_NW);
   endtask

   task automatic test_divide();
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b1, 1'b1);
      step();
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b1, 1'b0, 1'b0);
      total++; if (busy !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL div_e_start: got busy=%0b stall=%0b exp 0 1", busy, stall); end
      for (int i = 1; i <= 10; i++) begin
         step();
         total++; if (busy !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL div_cyc%0d: got busy=%0b stall=%0b exp 1 1", i, busy, stall); end
      end
      step();
      total++; if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL div_done: got busy=%0b stall=%0b exp 0 0", busy, stall); end
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_mult_count();
      int n;
      n = 0;
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b1, 1'b0);
      step();
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy === 1'b1) n++;
      end
      total++; if (n !== 5) begin bad++; $display("FAIL mult_len: got %0d exp 5", n); end
   endtask

   task automatic test_reset_mid_mult();
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b1, 1'b0);
      step();
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b1, 1'b0, 1'b0);
      step(); step(); step(); step();
      total++; if (busy !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL mult_c4: got busy=%0b stall=%0b exp 1 1", busy, stall); end
      #2 rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %0b exp 0", busy); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_stall: got %0b exp 0", stall); end
      total++; if ({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM} !== 10'd0) begin
         bad++; $display("FAIL arst_fwd: got %b exp 0000000000", {fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_residual: got %0b exp 0", stall); end
      step();
      total++; if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL arst_after: got busy=%0b stall=%0b exp 0 0", busy, stall); end
   endtask

   initial begin
      rst = 1'b1;
      set_w(5'd0, RES_NW);
      set_d(5'd0, 5'd0, 5'd0, RES_NW, TN, TN, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_load_use();
      test_alu_b2b();
      test_link();
      test_zero_nw();
      test_m_w_priority();
      test_divide();
      test_mult_count();
      test_reset_mid_mult();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
